// File: rtl/neopix_pkg.sv
// Shared NeoPixel timing and types for the driver and the loopback receiver.
// All timing values are in 50 MHz clock cycles.
package neopix_pkg;

    localparam int T0H_CYC   = 20;
    localparam int T1H_CYC   = 40;
    localparam int BIT_CYC   = 63;
    localparam int RESET_CYC = 2500;

    typedef struct packed {
        logic [7:0] g;
        logic [7:0] r;
        logic [7:0] b;
    } grb_t;

    typedef enum logic [1:0] {ARM, IDLE, HIGH, LOW} neo_rx_state_t;

endpackage

// File: rtl/neo_pulse_timer.sv
// Synchronizes the NeoPixel line and measures its high pulses and low gaps.
// Outputs refer to the synchronized level, which lags neo_in by 2 cycles.
module neo_pulse_timer #(
    parameter int MAX_HIGH     = 75,
    parameter int RESET_CYCLES = 2500,
    parameter int HW           = $clog2(MAX_HIGH + 2)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          neo_in,
    output logic          rise,
    output logic          fall,
    output logic [HW-1:0] high_width,
    output logic          gap_seen
);

    localparam int LW = $clog2(RESET_CYCLES + 1);

    // [0],[1] form the synchronizer; [2] is the previous synchronized level.
    logic [2:0]    sync;
    logic [LW-1:0] low_cnt;
    logic          lvl;

    assign lvl = sync[1];

    always_ff @(posedge clock) begin
        if (!reset) begin
            sync       <= '0;
            high_width <= '0;
            low_cnt    <= '0;
        end else begin
            sync <= {sync[1:0], neo_in};
            if (!lvl)
                high_width <= '0;
            else if (high_width < HW'(MAX_HIGH + 1))
                high_width <= high_width + 1'b1;
            if (lvl)
                low_cnt <= '0;
            else if (low_cnt < LW'(RESET_CYCLES))
                low_cnt <= low_cnt + 1'b1;
        end
    end

    // high_width holds the full pulse width in the cycle the fall is seen.
    assign rise     = lvl & ~sync[2];
    assign fall     = ~lvl & sync[2];
    assign gap_seen = ~lvl && (low_cnt == LW'(RESET_CYCLES - 1));

endmodule

// File: rtl/neopixel_rx.sv
// WS2812 receiver: decodes the one-wire waveform into indexed 24-bit GRB words.
// pixel_valid fires the cycle after bit 24's falling edge; frame_done on the reset gap.
module neopixel_rx
    import neopix_pkg::*;
#(
    parameter int MIN_HIGH     = 5,
    parameter int ONE_THRESH   = 30,
    parameter int MAX_HIGH     = 75,
    parameter int RESET_CYCLES = RESET_CYC,
    parameter int MAX_PIXELS   = 32
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            neo_in,
    output logic                            pixel_valid,
    output logic [$clog2(MAX_PIXELS)-1:0]   pixel_index,
    output logic [7:0]                      pixel_green,
    output logic [7:0]                      pixel_red,
    output logic [7:0]                      pixel_blue,
    output logic                            frame_done,
    output logic [$clog2(MAX_PIXELS+1)-1:0] pixel_count,
    output logic                            err_timing,
    output logic                            err_partial,
    output logic                            err_overflow
);

    localparam int HW = $clog2(MAX_HIGH + 2);
    localparam int IW = $clog2(MAX_PIXELS);
    localparam int CW = $clog2(MAX_PIXELS + 1);

    neo_rx_state_t state;
    logic [22:0]   shreg;
    logic [4:0]    bit_cnt;
    logic [CW-1:0] word_cnt;
    logic          bits_seen;
    logic          rise, fall, gap_seen;
    logic [HW-1:0] high_width;
    logic          bit_val;
    grb_t          pix;

    neo_pulse_timer #(
        .MAX_HIGH     (MAX_HIGH),
        .RESET_CYCLES (RESET_CYCLES),
        .HW           (HW)
    ) u_timer (
        .clock      (clock),
        .reset      (reset),
        .neo_in     (neo_in),
        .rise       (rise),
        .fall       (fall),
        .high_width (high_width),
        .gap_seen   (gap_seen)
    );

    assign bit_val = (high_width >= HW'(ONE_THRESH));
    assign pix     = grb_t'({shreg, bit_val});

    always_ff @(posedge clock) begin
        if (!reset) begin
            state        <= ARM;
            shreg        <= '0;
            bit_cnt      <= '0;
            word_cnt     <= '0;
            bits_seen    <= 1'b0;
            pixel_valid  <= 1'b0;
            pixel_index  <= '0;
            pixel_green  <= '0;
            pixel_red    <= '0;
            pixel_blue   <= '0;
            frame_done   <= 1'b0;
            pixel_count  <= '0;
            err_timing   <= 1'b0;
            err_partial  <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            pixel_valid <= 1'b0;
            frame_done  <= 1'b0;
            unique case (state)
                ARM: if (gap_seen) state <= IDLE;
                IDLE: if (rise) begin
                    state        <= HIGH;
                    bit_cnt      <= '0;
                    word_cnt     <= '0;
                    bits_seen    <= 1'b0;
                    err_timing   <= 1'b0;
                    err_partial  <= 1'b0;
                    err_overflow <= 1'b0;
                end
                HIGH: if (fall) begin
                    if (high_width < HW'(MIN_HIGH)) begin
                        state <= LOW;
                    end else if (high_width > HW'(MAX_HIGH)) begin
                        err_timing <= 1'b1;
                        bit_cnt    <= '0;
                        state      <= ARM;
                    end else begin
                        state     <= LOW;
                        bits_seen <= 1'b1;
                        if (bit_cnt == 5'd23) begin
                            bit_cnt <= '0;
                            // Words past MAX_PIXELS are counted as overflow only.
                            if (word_cnt < CW'(MAX_PIXELS)) begin
                                pixel_valid <= 1'b1;
                                pixel_index <= word_cnt[IW-1:0];
                                pixel_green <= pix.g;
                                pixel_red   <= pix.r;
                                pixel_blue  <= pix.b;
                                word_cnt    <= word_cnt + 1'b1;
                            end else begin
                                err_overflow <= 1'b1;
                            end
                        end else begin
                            shreg   <= {shreg[21:0], bit_val};
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                LOW: if (gap_seen) begin
                    state   <= IDLE;
                    bit_cnt <= '0;
                    if (bits_seen) begin
                        frame_done  <= 1'b1;
                        pixel_count <= word_cnt;
                        if (bit_cnt != 5'd0) err_partial <= 1'b1;
                    end
                end else if (rise) begin
                    state <= HIGH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neopixel_rx.sv
// Directed bench for neopixel_rx: drives WS2812 waveforms and checks decoded words, frame strobes and error flags.
module tb_neopixel_rx;
    import neopix_pkg::*;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       neo_in = 1'b0;
    logic       pixel_valid;
    logic [4:0] pixel_index;
    logic [7:0] pixel_green, pixel_red, pixel_blue;
    logic       frame_done;
    logic [5:0] pixel_count;
    logic       err_timing, err_partial, err_overflow;

    int n_checks = 0;
    int n_fail   = 0;
    int pv_cnt   = 0;
    int fd_cnt   = 0;
    int coinc    = 0;
    logic [4:0]  idx_q[$];
    logic [23:0] word_q[$];
    logic [5:0]  last_count = '0;

    int pv0, fd0, q0, bad;
    logic [23:0] w;

    neopixel_rx dut (
        .clock        (clock),
        .reset        (reset),
        .neo_in       (neo_in),
        .pixel_valid  (pixel_valid),
        .pixel_index  (pixel_index),
        .pixel_green  (pixel_green),
        .pixel_red    (pixel_red),
        .pixel_blue   (pixel_blue),
        .frame_done   (frame_done),
        .pixel_count  (pixel_count),
        .err_timing   (err_timing),
        .err_partial  (err_partial),
        .err_overflow (err_overflow)
    );

    always #10 clock = ~clock;

    always @(negedge clock) begin
        if (pixel_valid) begin
            pv_cnt = pv_cnt + 1;
            idx_q.push_back(pixel_index);
            word_q.push_back({pixel_green, pixel_red, pixel_blue});
        end
        if (frame_done) begin
            fd_cnt     = fd_cnt + 1;
            last_count = pixel_count;
        end
        if (pixel_valid && frame_done) coinc = coinc + 1;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input int hi, input int per);
        neo_in = 1'b1;
        repeat (hi) @(negedge clock);
        neo_in = 1'b0;
        repeat (per - hi) @(negedge clock);
    endtask

    task automatic send_word(input logic [23:0] wd, input bit fast);
        int hi;
        for (int i = 23; i >= 0; i--) begin
            hi = wd[i] ? T1H_CYC : T0H_CYC;
            send_bit(hi, fast ? hi + 5 : BIT_CYC);
        end
    endtask

    task automatic gap();
        neo_in = 1'b0;
        repeat (RESET_CYC + 50) @(negedge clock);
    endtask

    task automatic snap();
        pv0 = pv_cnt;
        fd0 = fd_cnt;
        q0  = idx_q.size();
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({pixel_valid, pixel_index, pixel_green, pixel_red, pixel_blue,
                    frame_done, pixel_count, err_timing, err_partial, err_overflow});
    endfunction

    initial begin
        repeat (5) @(negedge clock);
        check_val("reset_outputs", all_outs(), 64'd0);
        reset = 1'b1;
        gap();

        // One pixel at nominal timing.
        snap();
        send_word(24'hFF0080, 1'b0);
        gap();
        check_val("p1_valid_cnt", 64'(pv_cnt - pv0), 64'd1);
        check_val("p1_index", 64'(idx_q[q0]), 64'd0);
        check_val("p1_word", 64'(word_q[q0]), 64'hFF0080);
        check_val("p1_frame_done", 64'(fd_cnt - fd0), 64'd1);
        check_val("p1_count", 64'(last_count), 64'd1);
        check_val("p1_errs", 64'({err_timing, err_partial, err_overflow}), 64'd0);

        // Sixteen white pixels.
        snap();
        for (int p = 0; p < 16; p++) send_word(24'hFFFFFF, 1'b1);
        gap();
        check_val("p16_valid_cnt", 64'(pv_cnt - pv0), 64'd16);
        bad = 0;
        for (int p = 0; p < 16; p++)
            if (idx_q[q0+p] != 5'(p) || word_q[q0+p] != 24'hFFFFFF) bad++;
        check_val("p16_order_data", 64'(bad), 64'd0);
        check_val("p16_frame_done", 64'(fd_cnt - fd0), 64'd1);
        check_val("p16_count", 64'(last_count), 64'd16);
        check_val("p16_errs", 64'({err_timing, err_partial, err_overflow}), 64'd0);

        // Widths 29 -> 0, 30 -> 1, then a 4-cycle glitch that must not count.
        snap();
        w = 24'h5AC396;
        send_bit(29, BIT_CYC);
        send_bit(30, BIT_CYC);
        send_bit(4, BIT_CYC);
        for (int i = 21; i >= 0; i--) send_bit(w[i] ? T1H_CYC : T0H_CYC, BIT_CYC);
        gap();
        check_val("bnd_valid_cnt", 64'(pv_cnt - pv0), 64'd1);
        check_val("bnd_word", 64'(word_q[q0]), 64'h5AC396);
        check_val("bnd_count", 64'(last_count), 64'd1);
        check_val("bnd_errs", 64'({err_timing, err_partial, err_overflow}), 64'd0);

        // A 76-cycle high aborts the frame.
        snap();
        for (int i = 0; i < 10; i++) send_bit(T1H_CYC, BIT_CYC);
        send_bit(76, 96);
        for (int i = 0; i < 14; i++) send_bit(T0H_CYC, BIT_CYC);
        gap();
        check_val("tmg_valid_cnt", 64'(pv_cnt - pv0), 64'd0);
        check_val("tmg_frame_done", 64'(fd_cnt - fd0), 64'd0);
        check_val("tmg_err_timing", 64'(err_timing), 64'd1);
        check_val("tmg_other_errs", 64'({err_partial, err_overflow}), 64'd0);

        // 33 words: the last one overflows.
        snap();
        for (int p = 0; p < 33; p++) send_word(24'(p), 1'b1);
        gap();
        check_val("ovf_valid_cnt", 64'(pv_cnt - pv0), 64'd32);
        bad = 0;
        for (int p = 0; p < 32; p++)
            if (idx_q[q0+p] != 5'(p) || word_q[q0+p] != 24'(p)) bad++;
        check_val("ovf_order_data", 64'(bad), 64'd0);
        check_val("ovf_count", 64'(last_count), 64'd32);
        check_val("ovf_err_overflow", 64'(err_overflow), 64'd1);
        check_val("ovf_err_timing_cleared", 64'(err_timing), 64'd0);

        // 12 bits then a gap.
        snap();
        for (int i = 0; i < 12; i++) send_bit(T1H_CYC, BIT_CYC);
        gap();
        check_val("part_valid_cnt", 64'(pv_cnt - pv0), 64'd0);
        check_val("part_frame_done", 64'(fd_cnt - fd0), 64'd1);
        check_val("part_count", 64'(last_count), 64'd0);
        check_val("part_flags", 64'({err_timing, err_partial, err_overflow}), 64'b010);

        // Reset after bit 10 of a word; traffic is ignored until re-armed.
        snap();
        w = 24'hABCDEF;
        for (int i = 23; i >= 14; i--) send_bit(w[i] ? T1H_CYC : T0H_CYC, BIT_CYC);
        reset = 1'b0;
        @(negedge clock);
        check_val("mid_reset_outputs", all_outs(), 64'd0);
        reset = 1'b1;
        for (int i = 13; i >= 0; i--) send_bit(w[i] ? T1H_CYC : T0H_CYC, BIT_CYC);
        send_word(24'h111111, 1'b1);
        gap();
        check_val("rearm_ignored", 64'(pv_cnt - pv0), 64'd0);
        send_word(24'h123456, 1'b0);
        gap();
        check_val("rearm_valid_cnt", 64'(pv_cnt - pv0), 64'd1);
        check_val("rearm_index", 64'(idx_q[q0]), 64'd0);
        check_val("rearm_word", 64'(word_q[q0]), 64'h123456);
        check_val("rearm_frame_done", 64'(fd_cnt - fd0), 64'd1);
        check_val("rearm_count", 64'(last_count), 64'd1);

        check_val("valid_done_coincide", 64'(coinc), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/neopixel_rx.md
Name: neopixel_rx

Overview:
- Decodes a WS2812 "NeoPixel" one-wire waveform, the same waveform our ChipInterface drives on NEO_OUT, back into per-pixel 24-bit GRB words.
- Used as an on-chip loopback checker and as the self-checking monitor in pong/neopix benches.
- Acts as the consumer end of the protocol that the NeoPixel driver produces.
- Clocked at 50 MHz (CLOCK_50 domain); all timing constants are in clock cycles.

Parameters:
- MIN_HIGH, 5: high pulses shorter than this (cycles) are glitches and are ignored.
- ONE_THRESH, 30: high width >= this is a '1', otherwise a '0' (nominal T0H = 20 cycles, T1H = 40 cycles).
- MAX_HIGH, 75: high width > this is a timing error.
- RESET_CYCLES, 2500: line low for this many cycles ends a frame (50 us).
- MAX_PIXELS, 32: maximum words reported per frame.

Ports:
- clock  in  1  system clock (CLOCK_50).
- reset  in  1  synchronous, active-low reset.
- neo_in  in  1  asynchronous NeoPixel data line.
- pixel_valid  out  1  one-cycle strobe; the pixel fields below are valid.
- pixel_index  out  $clog2(MAX_PIXELS)  position of the word in the frame, 0-based.
- pixel_green  out  8  first byte received, MSB first.
- pixel_red  out  8  second byte.
- pixel_blue  out  8  third byte.
- frame_done  out  1  one-cycle strobe when the reset gap is detected after at least one rising edge.
- pixel_count  out  $clog2(MAX_PIXELS+1)  words accepted in the frame; valid with frame_done.
- err_timing  out  1  sticky: a high pulse exceeded MAX_HIGH.
- err_partial  out  1  sticky: the frame ended with 1..23 bits pending.
- err_overflow  out  1  sticky: more than MAX_PIXELS words were received.

Behaviour:
- Reset is synchronous and active-low. While reset==0, all outputs are 0, counters are cleared and state is ARM. Reset asserted mid-frame discards the partial word and the frame; after release the block re-arms.
- neo_in passes through a 2-flop synchronizer; all latencies below are measured from the synchronized signal (raw-to-synchronized delay is 2 cycles).
- States:
  - ARM: count consecutive low cycles. On reaching RESET_CYCLES, go to IDLE. Any high restarts the count, so a frame already in progress at power-up is never half-decoded.
  - IDLE: on a rising edge, go to HIGH. Clear the high counter, bit_cnt, word index and the three error flags.
  - HIGH: count high cycles; the counter saturates at MAX_HIGH+1. On a falling edge, classify:
    - width < MIN_HIGH: no bit, go to LOW.
    - width > MAX_HIGH: set err_timing, discard the word, go to ARM.
    - otherwise: shift bit (1 if width >= ONE_THRESH) into the 24-bit shift register, increment bit_cnt, go to LOW.
  - LOW: count low cycles; the counter saturates at RESET_CYCLES.
    - Rising edge before RESET_CYCLES: go to HIGH.
    - Reaching RESET_CYCLES: end of frame, go to IDLE.
- Word completion: when bit_cnt reaches 24, pixel_valid is asserted for exactly 1 cycle, in the cycle after the falling edge of bit 24 is seen.
  - Fields are registered from the shift register: [23:16]=G, [15:8]=R, [7:0]=B.
  - pixel_index is the word number; bit_cnt resets to 0.
  - Field outputs hold their value until the next pixel_valid.
- Overflow: words beyond MAX_PIXELS produce no pixel_valid, set err_overflow, and pixel_count saturates at MAX_PIXELS.
- Frame end: frame_done is asserted for 1 cycle in the cycle LOW reaches RESET_CYCLES.
  - pixel_count equals the number of accepted words.
  - If bit_cnt != 0, err_partial is set and the pending bits are discarded.
  - Error flags are valid with frame_done and remain stable until the next frame's first rising edge.
- Simultaneous events:
  - A word completion on the final bit followed by a gap: pixel_valid precedes frame_done by at least RESET_CYCLES cycles; they never coincide.
  - A reset gap with zero bits since IDLE produces no frame_done.
- The bit period is not checked; only high widths and the reset gap are timed.

Decomposition:
- Package neopix_pkg:
  - Timing localparams T0H_CYC=20, T1H_CYC=40, BIT_CYC=63, RESET_CYC=2500, shared with the NeoPixel driver.
  - typedef struct packed {logic [7:0] g, r, b;} grb_t.
  - typedef enum {ARM, IDLE, HIGH, LOW} neo_rx_state_t.
- Sub-module neo_pulse_timer: synchronizer, edge detect, and the saturating high/low counters. It outputs rise, fall, high_width and gap_seen.
- The top level holds the FSM, shift register, index and error logic.

Test Plan:
- Arm then one pixel: after reset, hold low 2500 cycles, then send G=0xFF R=0x00 B=0x80 (20/40-cycle highs, 63-cycle bits), then 2500 low -> one pixel_valid with index 0, g=FF r=00 b=80; frame_done with pixel_count=1; no errors.
- Sixteen pixels, all 0xFFFFFF as in the ChipInterface load test -> indices 0..15 in order; pixel_count=16; errors clear.
- Boundary widths: highs of 29, 30, 4 and 76 cycles ->
  - 29 decodes as 0, 30 decodes as 1.
  - 4 is ignored with bit_cnt unchanged.
  - 76 sets err_timing, with no pixel_valid for that word.
- 33 words with MAX_PIXELS=32 -> exactly 32 pixel_valid; err_overflow=1; pixel_count=32.
- 12 bits then a 2500-cycle gap -> no pixel_valid; frame_done with pixel_count=0 and err_partial=1.
- reset=0 for 1 cycle after bit 10 of a word -> all outputs 0. The following traffic is ignored until 2500 low cycles; the next full frame then decodes from index 0.
